// File: rtl/ifetch.sv
// ifetch: instruction fetch stage with a small prefetch queue.
//
// Issues sequential word-aligned reads to a synchronous instruction SRAM
// (data returns exactly one cycle after acceptance), buffers returned words
// together with their PC, and presents them to decode over valid/ready.
// A one-cycle redirect flushes the queue, drops any response landing in the
// redirect cycle and restarts fetch at the new (word-aligned) address.
//
// Parameters:
//   DEPTH     prefetch queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset (word aligned)
//
// Ports:
//   clk       clock, all state on rising edge
//   reset     asynchronous active-low reset
//   i_addr    SRAM word address (always the current fetch pc)
//   i_rd      SRAM read request, accepted when i_rd & i_ready
//   i_ready   SRAM can accept a request this cycle
//   i_data    SRAM read data, valid the cycle after acceptance
//   redir     redirect/flush strobe
//   redir_pc  redirect target; bits [1:0] are ignored
//   f_valid   f_ir/f_pc hold a valid instruction
//   f_ready   consumer accepts the instruction
//   f_ir      instruction word
//   f_pc      address the instruction was fetched from
//
// Build option:
//   IFETCH_BYPASS_EN  when defined, a response arriving to an empty queue is
//                     presented combinationally in the same cycle.
module ifetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] i_addr,
    output logic        i_rd,
    input  logic        i_ready,
    input  logic [31:0] i_data,
    input  logic        redir,
    input  logic [31:0] redir_pc,
    output logic        f_valid,
    input  logic        f_ready,
    output logic [31:0] f_ir,
    output logic [31:0] f_pc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   ir_q [DEPTH];
    logic [31:0]   pc_q [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic          discard;

    logic [CW-1:0] occupancy;
    logic          accept;
    logic          resp_ok;
    logic          push;
    logic          pop_q;
    logic          unused_redir_lsb;

    assign unused_redir_lsb = ^redir_pc[1:0];

    // Credit counts the outstanding request as occupied; a same-cycle pop
    // deliberately grants nothing extra so the queue can never overflow.
    assign occupancy = count + {{(CW-1){1'b0}}, inflight};
    assign i_rd      = reset & ~redir & (occupancy < DEPTH_C);
    assign i_addr    = fetch_pc;
    assign accept    = i_rd & i_ready;

    // A response landing in a redirect cycle, or one marked stale, is dropped.
    assign resp_ok   = inflight & ~discard & ~redir;

`ifdef IFETCH_BYPASS_EN
    logic bypass;

    assign bypass  = resp_ok & (count == '0);
    assign f_valid = (count != '0) | bypass;
    assign f_ir    = bypass ? i_data      : ir_q[rd_ptr];
    assign f_pc    = bypass ? inflight_pc : pc_q[rd_ptr];
    // A bypassed word that is taken immediately never enters the queue.
    assign push    = resp_ok & ~(bypass & f_ready);
    assign pop_q   = (count != '0) & f_ready & ~redir;
`else
    assign f_valid = (count != '0);
    assign f_ir    = ir_q[rd_ptr];
    assign f_pc    = pc_q[rd_ptr];
    assign push    = resp_ok;
    assign pop_q   = f_valid & f_ready & ~redir;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            discard     <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ir_q[i] <= '0;
                pc_q[i] <= '0;
            end
        end else if (redir) begin
            fetch_pc <= {redir_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= accept;
            // Only a request accepted alongside the redirect would return
            // after it; anything already in flight lands now and is dropped.
            discard  <= accept;
        end else begin
            if (accept) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
            inflight <= accept;
            if (inflight) begin
                discard <= 1'b0;
            end
            if (push) begin
                ir_q[wr_ptr] <= i_data;
                pc_q[wr_ptr] <= inflight_pc;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop_q) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop_q})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
